ascon_msg_packer: RTL and testbench

Byte-stream front end for the Ascon hash datapath. It accepts message bytes over a valid/ready handshake and packs them MSB-first into 64-bit rate blocks. It applies Ascon-Hash padding (a 0x80 byte followed by zero bytes) and presents each block with its `last` descriptor on the datapath's absorption interface (`new_block`, `last`). It is the producer end of that interface and sits between the host/byte source and `ascon_datapath`.

---
 rtl/ascon_pkg.sv | 35 +++
 rtl/ascon_msg_packer.sv | 123 ++++++++++++
 tb/tb_ascon_msg_packer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared constants, types and padding helper for the Ascon hash front end.
// The packer builds 64-bit rate blocks MSB-first, byte 0 in bits [63:56].
package ascon_pkg;

  localparam int          BYTES_PER_BLK  = 8;
  localparam logic [7:0]  PAD_BYTE       = 8'h80;
  localparam int          LAST_FINAL_BIT = 8;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    EMIT     = 2'd1,
    EMIT_PAD = 2'd2
  } packer_state_t;

  typedef struct packed {
    logic [63:0] block;
    logic [7:0]  mask;
  } padded_t;

  // Keeps the first cnt bytes of data, puts PAD_BYTE at index cnt and zeros after it.
  function automatic padded_t pad_block(input logic [63:0] data, input logic [2:0] cnt);
    padded_t r;
    r = '0;
    for (int i = 0; i < BYTES_PER_BLK; i++) begin
      if (i < int'(cnt)) begin
        r.block[63-8*i -: 8] = data[63-8*i -: 8];
        r.mask[7-i]          = 1'b1;
      end else if (i == int'(cnt)) begin
        r.block[63-8*i -: 8] = PAD_BYTE;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ascon_msg_packer.sv
// Byte-stream packer: collects message bytes into 64-bit rate blocks,
// applies Ascon-Hash padding and hands blocks to the datapath.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   COLLECT  | accepting bytes into blk_reg at index cnt
//   EMIT     | presenting a data block (full or final padded) to datapath
//   EMIT_PAD | presenting the extra pad-only block after a full final block
module ascon_msg_packer
  import ascon_pkg::*;
#(
  parameter int BW = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  input  logic          s_last,
  input  logic          s_null,
  output logic          s_ready,
  output logic [BW-1:0] new_block,
  output logic [8:0]    last,
  output logic          blk_valid,
  input  logic          blk_ready
);

  packer_state_t state;
  logic [2:0]    cnt;
  logic          pad_pending;
  logic [63:0]   blk_reg;

  logic [63:0]   merged;
  padded_t       pad_byte_res;
  padded_t       pad_null_res;
  logic          accept;

  assign accept = s_valid && s_ready;

  // Index k sits at bit offset (7-k)*8, i.e. {~k, 3'b000} for a 3-bit k.
  always_comb begin
    merged = blk_reg;
    merged[{~cnt, 3'b000} +: 8] = s_data;
    pad_byte_res = pad_block(merged, cnt + 3'd1);
    pad_null_res = pad_block(blk_reg, cnt);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= COLLECT;
      cnt         <= 3'd0;
      pad_pending <= 1'b0;
      blk_reg     <= 64'h0;
      new_block   <= '0;
      last        <= 9'h000;
      blk_valid   <= 1'b0;
      s_ready     <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          s_ready <= 1'b1;
          if (accept && !s_null) begin
            blk_reg <= merged;
            cnt     <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              new_block   <= merged;
              last        <= 9'h0FF;
              pad_pending <= s_last;
              blk_valid   <= 1'b1;
              s_ready     <= 1'b0;
              state       <= EMIT;
            end else if (s_last) begin
              new_block <= pad_byte_res.block;
              last      <= {1'b1, pad_byte_res.mask};
              blk_valid <= 1'b1;
              s_ready   <= 1'b0;
              state     <= EMIT;
            end
          end else if (accept && s_last) begin
            new_block <= pad_null_res.block;
            last      <= {1'b1, pad_null_res.mask};
            blk_valid <= 1'b1;
            s_ready   <= 1'b0;
            state     <= EMIT;
          end
        end

        EMIT: begin
          if (blk_ready) begin
            cnt     <= 3'd0;
            blk_reg <= 64'h0;
            if (pad_pending) begin
              new_block <= {PAD_BYTE, 56'h0};
              last      <= 9'h100;
              state     <= EMIT_PAD;
            end else begin
              blk_valid <= 1'b0;
              s_ready   <= 1'b1;
              state     <= COLLECT;
            end
          end
        end

        EMIT_PAD: begin
          if (blk_ready) begin
            pad_pending <= 1'b0;
            blk_valid   <= 1'b0;
            s_ready     <= 1'b1;
            cnt         <= 3'd0;
            blk_reg     <= 64'h0;
            state       <= COLLECT;
          end
        end

        default: begin
          state     <= COLLECT;
          blk_valid <= 1'b0;
          s_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_msg_packer.sv
// Scoreboard bench for ascon_msg_packer: messages are turned into expected
// blocks by a byte-level model; a monitor compares each handshaked block.
module tb_ascon_msg_packer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_null = 1'b0;
  logic        s_ready;
  logic [63:0] new_block;
  logic [8:0]  last;
  logic        blk_valid;
  logic        blk_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] blk;
    logic [8:0]  lst;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  bit   auto_rdy = 1'b1;
  bit   rand_rdy = 1'b0;

  logic [63:0] hold_blk;
  logic [8:0]  hold_lst;
  bit          hold_pend = 1'b0;

  ascon_msg_packer #(.BW(64)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_null    (s_null),
    .s_ready   (s_ready),
    .new_block (new_block),
    .last      (last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: full 8-byte chunks are non-final; the tail (possibly empty)
  // gets 0x80 then zeros and is the final block.
  task automatic expect_msg(input logic [7:0] msg[$]);
    int   n;
    int   full;
    int   r;
    exp_t e;
    logic [7:0] v;
    n    = msg.size();
    full = n / 8;
    r    = n % 8;
    for (int b = 0; b < full; b++) begin
      e.blk = 64'h0;
      for (int i = 0; i < 8; i++) e.blk = (e.blk << 8) | 64'(msg[b*8+i]);
      e.lst = 9'h0FF;
      exp_q.push_back(e);
    end
    e.blk = 64'h0;
    e.lst = 9'h100;
    for (int i = 0; i < 8; i++) begin
      if (i < r)       v = msg[full*8+i];
      else if (i == r) v = 8'h80;
      else             v = 8'h00;
      e.blk = (e.blk << 8) | 64'(v);
      if (i < r) e.lst[7-i] = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic beat(input logic [7:0] d, input bit l, input bit nul);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    s_null  = nul;
    while (!s_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout actual=s_ready_low required=s_ready_high");
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_null  = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic send_msg(input logic [7:0] msg[$], input bit null_term, input bit noise);
    int n;
    n = msg.size();
    expect_msg(msg);
    for (int i = 0; i < n; i++) begin
      if (noise && ($urandom_range(0, 3) == 0)) begin
        if ($urandom_range(0, 1) == 1) beat(8'($urandom), 1'b0, 1'b1);
        else @(negedge clk);
      end
      beat(msg[i], (i == n - 1) && !null_term, 1'b0);
    end
    if (n == 0 || null_term) beat(8'($urandom), 1'b1, 1'b1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (auto_rdy) blk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rstn) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 64'(blk_valid), 64'd1);
        check("hold_block", new_block, hold_blk);
        check("hold_last", 64'(last), 64'(hold_lst));
        hold_pend = 1'b0;
      end
      if (blk_valid) begin
        check("s_ready_while_valid", 64'(s_ready), 64'd0);
        if (blk_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_block actual=%h/%h required=none", new_block, last);
          end else begin
            me = exp_q.pop_front();
            check("block", new_block, me.blk);
            check("last", 64'(last), 64'(me.lst));
          end
        end else begin
          hold_pend = 1'b1;
          hold_blk  = new_block;
          hold_lst  = last;
        end
      end
    end
  end

  initial begin
    logic [7:0] m[$];

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_blk_valid", 64'(blk_valid), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_new_block", new_block, 64'd0);
    check("rst_last", 64'(last), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_s_ready", 64'(s_ready), 64'd1);

    // abc -> single padded final block, valid right after the accepting edge
    m = {8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0, 1'b0);
    check("latency_valid", 64'(blk_valid), 64'd1);
    drain("drain_abc");

    m = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send_msg(m, 1'b0, 1'b0);
    drain("drain_full8");

    m = {};
    send_msg(m, 1'b1, 1'b0);
    drain("drain_empty_msg");

    m = {};
    for (int i = 0; i < 11; i++) m.push_back(8'(8'h10 + i));
    send_msg(m, 1'b0, 1'b0);
    drain("drain_11");

    // Back-pressure: hold blk_ready low for 5 valid cycles
    @(posedge clk);
    #2;
    auto_rdy  = 1'b0;
    blk_ready = 1'b0;
    @(negedge clk);
    m = {8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(blk_valid), 64'd1);
      check("bp_s_ready", 64'(s_ready), 64'd0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #2;
    blk_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_done_valid", 64'(blk_valid), 64'd0);
    check("bp_done_s_ready", 64'(s_ready), 64'd1);
    check("bp_queue", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #2;
    auto_rdy = 1'b1;
    @(negedge clk);

    // Reset after 5 bytes discards the partial message
    for (int i = 1; i <= 5; i++) beat(8'(i), 1'b0, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_valid", 64'(blk_valid), 64'd0);
    check("midrst_s_ready", 64'(s_ready), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_rel_ready", 64'(s_ready), 64'd1);
    m = {8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0, 1'b0);
    drain("drain_after_rst");

    // 16 bytes ended by a null terminator after the second full block
    m = {};
    for (int i = 0; i < 16; i++) m.push_back(8'(8'hA0 + i));
    send_msg(m, 1'b1, 1'b0);
    drain("drain_null_term");

    // Randomized messages, noise beats and random back-pressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int len;
      len = $urandom_range(0, 20);
      m = {};
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      send_msg(m, 1'($urandom_range(0, 1)), 1'b1);
    end
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
